// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch/decode slice.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/ready handshake between fetch stage and memory.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/pc_next.sv
// Combinational next-PC select: jump beats taken branch, otherwise fall through.
module pc_next (
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        pc_src,
  input  logic        jump,
  output logic [31:0] next_pc
);

  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        unused_opcode;

  // Opcode bits are decoded by the control unit, not here.
  assign unused_opcode = ^instr[31:26];

  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = jump_target;
    else if (pc_src)
      next_pc = branch_target;
    next_pc[1:0] = 2'b00;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, IDLE/FETCH/ISSUE sequencing and retirement count.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master imem,
  input  logic          pc_src,
  input  logic          jump,
  input  logic          stall,
  output logic [31:0]   instr,
  output logic [5:0]    op,
  output logic [5:0]    funct,
  output logic          instr_valid,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus4,
  output logic [31:0]   retired
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, instr_q, retired_q, next_pc;
  logic         load_instr, advance;

  always_comb begin
    state_d    = state_q;
    load_instr = 1'b0;
    advance    = 1'b0;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: if (imem.imem_ready) begin
        state_d    = ISSUE;
        load_instr = 1'b1;
      end
      ISSUE: if (!stall) begin
        state_d = FETCH;
        advance = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset wins over any same-cycle ready or retirement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= {RESET_PC[31:2], 2'b00};
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_instr)
        instr_q <= imem.imem_rdata;
      if (advance) begin
        pc_q      <= next_pc;
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  pc_next u_pc_next (
    .pc_plus4 (pc_plus4),
    .instr    (instr_q),
    .pc_src   (pc_src),
    .jump     (jump),
    .next_pc  (next_pc)
  );

  assign pc_plus4       = pc_q + 32'd4;
  assign pc             = pc_q;
  assign instr          = instr_q;
  assign op             = instr_q[31:26];
  assign funct          = instr_q[5:0];
  assign retired        = retired_q;
  assign instr_valid    = (state_q == ISSUE);
  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic against a reference model.
module tb_instr_fetch;
  import mips_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, pc_src, jump, stall, ready;
  logic [31:0] rdata;

  logic [31:0] instr, pc, pc_plus4, retired;
  logic [5:0]  op, funct;
  logic        instr_valid;

  logic [31:0] j_instr, j_pc, j_pc_plus4, j_retired;
  logic [5:0]  j_op, j_funct;
  logic        j_instr_valid;

  instr_fetch_if bus ();
  instr_fetch_if bus_j ();

  assign bus.imem_ready   = ready;
  assign bus.imem_rdata   = rdata;
  assign bus_j.imem_ready = ready;
  assign bus_j.imem_rdata = rdata;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem(bus), .pc_src(pc_src), .jump(jump), .stall(stall),
    .instr(instr), .op(op), .funct(funct), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .retired(retired)
  );

  instr_fetch #(.RESET_PC(32'h4000_0000)) dut_j (
    .clk(clk), .rst_n(rst_n), .imem(bus_j), .pc_src(pc_src), .jump(jump), .stall(stall),
    .instr(j_instr), .op(j_op), .funct(j_funct), .instr_valid(j_instr_valid),
    .pc(j_pc), .pc_plus4(j_pc_plus4), .retired(j_retired)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: phase 0 = waiting after reset, 1 = fetching, 2 = instruction held
  int          m_phase   = 0;
  logic [31:0] m_pc      = 32'h0;
  logic [31:0] m_instr   = 32'h0;
  logic [31:0] m_retired = 32'h0;

  function automatic logic [31:0] ref_target(input logic [31:0] cur_pc, input logic [31:0] word,
                                             input bit j, input bit b);
    logic [31:0] p4;
    p4 = cur_pc + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    if (b) return p4 + 32'($signed(word[15:0])) * 32'd4;
    return p4;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_phase = 0; m_pc = 32'h0; m_instr = 32'h0; m_retired = 32'h0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (ready) begin
        m_instr = rdata;
        m_phase = 2;
      end
    end else if (!stall) begin
      m_pc      = ref_target(m_pc, m_instr, jump, pc_src);
      m_retired = m_retired + 32'd1;
      m_phase   = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("pc",          pc,                     m_pc);
    chk("imem_addr",   bus.imem_addr,          m_pc);
    chk("pc_plus4",    pc_plus4,               m_pc + 32'd4);
    chk("imem_req",    {31'b0, bus.imem_req},  {31'b0, m_phase == 1});
    chk("instr_valid", {31'b0, instr_valid},   {31'b0, m_phase == 2});
    chk("instr",       instr,                  m_instr);
    chk("op",          {26'b0, op},            m_instr >> 26);
    chk("funct",       {26'b0, funct},         m_instr & 32'h3F);
    chk("retired",     retired,                m_retired);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; ready = 1'b0; stall = 1'b0; jump = 1'b0; pc_src = 1'b0; rdata = 32'h0;
    cyc(); cyc();
    chk("rst_pc",     pc,       32'h0);
    chk("rst_pc4",    pc_plus4, 32'h4);
    chk("rst_req",    {31'b0, bus.imem_req}, 32'h0);
    chk("rst_j_pc4",  j_pc_plus4, 32'h4000_0004);

    // Sequential fetch with ready tied high
    rst_n = 1'b1;
    cyc();
    chk("first_req", {31'b0, bus.imem_req}, 32'h1);
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("seq_addr", bus.imem_addr, 32'(4 * i));
      rdata = 32'h0000_0020 + 32'(i);
      cyc();
      chk("seq_valid", {31'b0, instr_valid}, 32'h1);
      cyc();
    end
    chk("seq_retired", retired, 32'd3);

    // Jump to 0x10, then memory wait states there
    rdata = 32'h0800_0004; cyc(); jump = 1'b1; cyc(); jump = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_addr", bus.imem_addr, 32'h10);
      chk("wait_req",  {31'b0, bus.imem_req}, 32'h1);
      cyc();
    end
    chk("wait_addr4", bus.imem_addr, 32'h10);
    ready = 1'b1; rdata = 32'h8C08_0004;
    cyc();
    chk("wait_instr", instr, 32'h8C08_0004);
    chk("wait_op",    {26'b0, op}, {26'b0, OP_LW});
    cyc();

    // Jump to 0x20, then taken beq with offset -2
    rdata = 32'h0800_0008; cyc(); jump = 1'b1; cyc(); jump = 1'b0;
    chk("br_pc0", pc, 32'h20);
    rdata = 32'h1000_FFFE; cyc(); pc_src = 1'b1; cyc(); pc_src = 1'b0;
    chk("br_pc", pc, 32'h1C);

    // Jump to 0, branch back to 0xFFFF_FFFC, then stall and wrap
    rdata = 32'h0800_0000; cyc(); jump = 1'b1; cyc(); jump = 1'b0;
    rdata = 32'h1000_FFFE; cyc(); pc_src = 1'b1; cyc(); pc_src = 1'b0;
    chk("wrap_pc0", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0);
    rdata = 32'h2008_0001; cyc();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("stall_valid",   {31'b0, instr_valid}, 32'h1);
      chk("stall_pc",      pc, 32'hFFFF_FFFC);
      chk("stall_retired", retired, 32'd9);
    end
    stall = 1'b0;
    cyc();
    chk("wrap_pc",      pc, 32'h0);
    chk("wrap_retired", retired, 32'd10);

    // Jump priority on the instance reset to 0x4000_0000
    rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
    chk("jp_pc0", j_pc, 32'h4000_0000);
    rdata = 32'h0800_0040; cyc();
    jump = 1'b1; pc_src = 1'b1;
    cyc();
    jump = 1'b0; pc_src = 1'b0;
    chk("jp_pc", j_pc, 32'h4000_0100);

    // Reset during FETCH with ready high in the same cycle
    rdata = 32'hDEAD_BEEF; ready = 1'b1; rst_n = 1'b0;
    cyc();
    chk("mr_instr",   instr,   32'h0);
    chk("mr_pc",      pc,      32'h0);
    chk("mr_retired", retired, 32'h0);
    chk("mr_req",     {31'b0, bus.imem_req}, 32'h0);
    chk("mr_valid",   {31'b0, instr_valid},  32'h0);
    rst_n = 1'b1;
    cyc();
    chk("mr_refetch", {31'b0, bus.imem_req}, 32'h1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst_n  = ($urandom_range(0, 49) != 0);
      ready  = ($urandom_range(0, 9) < 7);
      stall  = ($urandom_range(0, 3) == 0);
      jump   = ($urandom_range(0, 3) == 0);
      pc_src = ($urandom_range(0, 2) == 0);
      rdata  = $urandom;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
